// File: rtl/disp_window_gen3x3.sv
// disp_window_gen3x3
// Streaming 3x3 window generator between the SGM disparity output stage and
// the 3x3 median filter. Raster-order pixels come in and two line buffers hold
// the previous two image lines. One registered 3x3 neighbourhood is emitted
// per interior pixel, with a one-clock latency from pixel acceptance.
// Optional build macro DISP_WIN_POS_EN adds the win_row/win_col outputs,
// which carry the centre coordinate of the current window.
module disp_window_gen3x3 #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       win_valid,
    input  logic                       win_ready,
`ifdef DISP_WIN_POS_EN
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
`endif
    output logic [WIDTH-1:0]           win_1,
    output logic [WIDTH-1:0]           win_2,
    output logic [WIDTH-1:0]           win_3,
    output logic [WIDTH-1:0]           win_4,
    output logic [WIDTH-1:0]           win_5,
    output logic [WIDTH-1:0]           win_6,
    output logic [WIDTH-1:0]           win_7,
    output logic [WIDTH-1:0]           win_8,
    output logic [WIDTH-1:0]           win_9,
    output logic                       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]    col_q, col_d, col_cur;
    logic [RW-1:0]    row_q, row_d, row_cur;
    logic [WIDTH-1:0] buf0_q [IMG_W];   // row r-2
    logic [WIDTH-1:0] buf1_q [IMG_W];   // row r-1
    logic [WIDTH-1:0] rd0, rd1;
    logic [WIDTH-1:0] win_q [9];
    logic [WIDTH-1:0] win_d [9];
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             acc, last_col, last_row, win_new;

    // The window register is the only output stage, so a new pixel can be
    // taken whenever it is empty or being drained this cycle.
    assign in_ready = !win_valid_q || win_ready;
    assign acc      = in_valid && in_ready;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign col_cur  = in_sof ? '0 : col_q;
    assign row_cur  = in_sof ? '0 : row_q;
    assign last_col = (col_cur == COL_LAST);
    assign last_row = (row_cur == ROW_LAST);
    assign win_new  = acc && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);

    // The line buffers are read combinationally so that the window register
    // can be loaded in the same cycle that the pixel is accepted.
    assign rd0 = buf0_q[col_cur];
    assign rd1 = buf1_q[col_cur];

    // Raster position advance: column first, then row, and both wrap at end of frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    // Each window row shifts left; the new column enters from the right
    always_comb begin
        win_d = win_q;
        if (acc) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = rd0;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = rd1;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = in_data;
        end
    end

    // Valid is set by a new window, cleared by a handshake, and held otherwise
    always_comb begin
        if (win_new) begin
            win_valid_d = 1'b1;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end
        frame_done_d = acc && last_col && last_row;
    end

    // Control state and the window shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers age by one line per accepted pixel; their contents are
    // always rewritten before being emitted, so they need no reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            buf0_q[col_cur] <= rd1;
            buf1_q[col_cur] <= in_data;
        end
    end

`ifdef DISP_WIN_POS_EN
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;

    // The centre coordinate is captured alongside each new window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (win_new) begin
            win_row_q <= row_cur - 1'b1;
            win_col_q <= col_cur - 1'b1;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_1 = win_q[0];
    assign win_2 = win_q[1];
    assign win_3 = win_q[2];
    assign win_4 = win_q[3];
    assign win_5 = win_q[4];
    assign win_6 = win_q[5];
    assign win_7 = win_q[6];
    assign win_8 = win_q[7];
    assign win_9 = win_q[8];

endmodule
